// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access adapter: access sizes, FSM states,
// and the read-wait counter width.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int RD_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_PULSE = 3'd2,
        ST_WR_WAIT  = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/mem_access_adapter_byte_lane_unit.sv
// Combinational lane logic: extracts a sub-word load result from a memory word
// and merges sub-word store data into a memory word.
module byte_lane_unit
    import mem_access_pkg::*;
#(
    parameter int LITTLE_ENDIAN = 1
) (
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_sign_ext,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic [31:0] o_merged
);

    logic [4:0]  w_bsh;
    logic [4:0]  w_hsh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_bsh  = (LITTLE_ENDIAN != 0) ? {i_lane, 3'b000} : {~i_lane, 3'b000};
        w_hsh  = (LITTLE_ENDIAN != 0) ? {i_lane[1], 4'b0000} : {~i_lane[1], 4'b0000};
        w_byte = i_word[w_bsh +: 8];
        w_half = i_word[w_hsh +: 16];
        case (i_size)
            SZ_BYTE: o_rdata = {{24{i_sign_ext & w_byte[7]}}, w_byte};
            SZ_HALF: o_rdata = {{16{i_sign_ext & w_half[15]}}, w_half};
            default: o_rdata = i_word;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            // Byte address held by physical slot gi of the data bus.
            localparam logic [1:0] AB = 2'((LITTLE_ENDIAN != 0) ? gi : 3 - gi);
            logic       w_en;
            logic [7:0] w_src;

            always_comb begin
                case (i_size)
                    SZ_BYTE: begin
                        w_en  = (i_lane == AB);
                        w_src = i_wdata[7:0];
                    end
                    SZ_HALF: begin
                        w_en  = (i_lane[1] == AB[1]);
                        w_src = i_wdata[(gi % 2) * 8 +: 8];
                    end
                    default: begin
                        w_en  = 1'b1;
                        w_src = i_wdata[gi * 8 +: 8];
                    end
                endcase
            end

            assign o_merged[gi * 8 +: 8] = w_en ? w_src : i_word[gi * 8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_access_adapter.sv
// Load/store adapter onto an aligned word-only memory port, with RMW for sub-word
// stores. Optional misalignment trap enabled by defining MEM_ALIGN_EXC_EN.
module mem_access_adapter
    import mem_access_pkg::*;
#(
    parameter int RD_WAIT_CYCLES = 1,
    parameter int LITTLE_ENDIAN  = 1
) (
    input  logic        clk50M,
    input  logic        rst_n,
    input  logic        req,
    input  logic        is_write,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        addr_err,
    output logic [31:0] pm_addr,
    output logic        pm_is_write,
    output logic [31:0] pm_wdata,
    input  logic [31:0] pm_rdata,
    input  logic        pm_busy
);

    localparam logic [RD_CNT_W-1:0] RD_LAST = RD_CNT_W'(RD_WAIT_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_is_write;
    logic [1:0]          r_size;
    logic                r_sign_ext;
    logic [1:0]          r_lane;
    logic [31:0]         r_wdata;
    logic [RD_CNT_W-1:0] r_cnt;
    logic [31:0]         r_rdata;
    logic [31:0]         r_pm_addr;
    logic [31:0]         r_pm_wdata;
    logic                w_rd_hit;
    logic                w_misal;
    logic                w_err;
    logic [31:0]         w_extract;
    logic [31:0]         w_merged;

`ifdef MEM_ALIGN_EXC_EN
    logic r_misal;
    assign w_misal = ((size == SZ_HALF) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            r_misal <= 1'b0;
        end else if (r_state == ST_IDLE && req) begin
            r_misal <= w_misal;
        end
    end
    assign w_err = r_misal;
`else
    assign w_misal = 1'b0;
    assign w_err   = 1'b0;
`endif

    assign w_rd_hit = (r_cnt == RD_LAST) && !pm_busy;

    byte_lane_unit #(.LITTLE_ENDIAN(LITTLE_ENDIAN)) u_lane (
        .i_word     (pm_rdata),
        .i_lane     (r_lane),
        .i_size     (r_size),
        .i_sign_ext (r_sign_ext),
        .i_wdata    (r_wdata),
        .o_rdata    (w_extract),
        .o_merged   (w_merged)
    );

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    if (w_misal)                 w_state_next = ST_DONE;
                    else if (is_write && size[1]) w_state_next = ST_WR_PULSE;
                    else                         w_state_next = ST_RD;
                end
            end
            ST_RD:       if (w_rd_hit) w_state_next = r_is_write ? ST_WR_PULSE : ST_DONE;
            ST_WR_PULSE: w_state_next = ST_WR_WAIT;
            ST_WR_WAIT:  if (!pm_busy) w_state_next = ST_DONE;
            ST_DONE:     w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready       = (r_state == ST_DONE);
        pm_is_write = (r_state == ST_WR_PULSE);
        addr_err    = (r_state == ST_DONE) && w_err;
    end

    // Request latches and datapath; a trapped access leaves the memory port untouched.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            r_is_write <= 1'b0;
            r_size     <= 2'b00;
            r_sign_ext <= 1'b0;
            r_lane     <= 2'b00;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_pm_addr  <= '0;
            r_pm_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_is_write <= is_write;
                        r_size     <= size;
                        r_sign_ext <= sign_ext;
                        r_lane     <= addr[1:0];
                        r_wdata    <= wdata;
                        r_cnt      <= '0;
                        r_rdata    <= '0;
                        if (!w_misal) begin
                            r_pm_addr <= {addr[31:2], 2'b00};
                            if (is_write) r_pm_wdata <= wdata;
                        end
                    end
                end
                ST_RD: begin
                    if (w_rd_hit) begin
                        if (r_is_write) r_pm_wdata <= w_merged;
                        else            r_rdata    <= w_extract;
                    end else if (r_cnt != RD_LAST) begin
                        r_cnt <= r_cnt + RD_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata    = r_rdata;
    assign pm_addr  = r_pm_addr;
    assign pm_wdata = r_pm_wdata;

endmodule

// File: tb/tb_mem_access_adapter.sv
// Scoreboard bench for mem_access_adapter with a behavioural word memory on the
// physical port; expected results come from a byte-array reference model.
module tb_mem_access_adapter;
    import mem_access_pkg::*;

    logic        clk50M = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        is_write = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        pm_busy = 1'b0;
    logic [31:0] rdata, pm_addr, pm_wdata, pm_rdata;
    logic        ready, addr_err, pm_is_write;

    logic [31:0] mem [0:63];
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          pulses;
        logic [31:0] wr_data;
        logic [31:0] addr;
    } exp_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          pulses;
        logic [31:0] wr_data;
        logic [31:0] wr_addr;
        logic [31:0] seen_addr;
        int          drop_to_ready;
        logic        done;
    } obs_t;

    exp_t sb_q[$];

    always #10 clk50M = ~clk50M;
    always @(posedge clk50M) cyc <= cyc + 1;
    assign pm_rdata = mem[pm_addr[7:2]];

    mem_access_adapter #(.RD_WAIT_CYCLES(1), .LITTLE_ENDIAN(1)) dut (
        .clk50M(clk50M), .rst_n(rst_n), .req(req), .is_write(is_write), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .addr_err(addr_err), .pm_addr(pm_addr), .pm_is_write(pm_is_write),
        .pm_wdata(pm_wdata), .pm_rdata(pm_rdata), .pm_busy(pm_busy)
    );

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a,
                                             input logic [1:0] sz, input logic sx);
        logic [7:0]  b [4];
        logic [7:0]  v8;
        logic [15:0] v16;
        int h;
        for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
        h   = a[1] ? 2 : 0;
        v8  = b[a[1:0]];
        v16 = {b[h+1], b[h]};
        case (sz)
            2'b00:   return sx ? {{24{v8[7]}}, v8} : {24'h0, v8};
            2'b01:   return sx ? {{16{v16[15]}}, v16} : {16'h0, v16};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [31:0] a,
                                              input logic [1:0] sz, input logic [31:0] wd);
        logic [7:0] b [4];
        int h;
        for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
        h = a[1] ? 2 : 0;
        case (sz)
            2'b00: b[a[1:0]] = wd[7:0];
            2'b01: begin b[h] = wd[7:0]; b[h+1] = wd[15:8]; end
            default: return wd;
        endcase
        return {b[3], b[2], b[1], b[0]};
    endfunction

    // Drives one request, acts as the physical memory, and records what the DUT did.
    task automatic run_access(input logic w, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int busy_hold, output obs_t o);
        int n = 0;
        int left = 0;
        int drop = -1;
        o = '{rd: '0, err: 1'b0, lat: 0, pulses: 0, wr_data: '0, wr_addr: '0,
              seen_addr: '0, drop_to_ready: -1, done: 1'b0};
        @(negedge clk50M);
        req = 1'b1; is_write = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk50M);
            if (k == 0) begin n = cyc; o.seen_addr = pm_addr; end
            if (pm_is_write) begin
                o.pulses++;
                o.wr_data = pm_wdata;
                o.wr_addr = pm_addr;
                mem[pm_addr[7:2]] = pm_wdata;
                if (busy_hold > 0) begin pm_busy = 1'b1; left = busy_hold; end
            end else if (left > 0) begin
                left--;
                if (left == 0) begin pm_busy = 1'b0; drop = cyc; end
            end
            if (ready) begin
                o.rd = rdata; o.err = addr_err; o.lat = cyc - n + 1;
                o.drop_to_ready = cyc - drop; o.done = 1'b1;
                break;
            end
        end
        req = 1'b0; pm_busy = 1'b0;
        $display("txn w=%0d sz=%0d sx=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d pulses=%0d",
                 w, sz, sx, a, wd, o.rd, o.err, o.lat, o.pulses);
    endtask

    task automatic test_reset();
        #5;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", ready); end
        checks++; if (pm_is_write !== 1'b0) begin failures++; $display("FAIL rst_pm_is_write got=%b exp=0", pm_is_write); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
        checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL rst_addr_err got=%b exp=0", addr_err); end
        checks++; if (pm_addr !== 32'h0) begin failures++; $display("FAIL rst_pm_addr got=%h exp=0", pm_addr); end
        checks++; if (pm_wdata !== 32'h0) begin failures++; $display("FAIL rst_pm_wdata got=%h exp=0", pm_wdata); end
        @(negedge clk50M); rst_n = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_lw();
        obs_t o; exp_t e;
        mem[4] = 32'hDEADBEEF;
        sb_q.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, lat: 2, pulses: 0, wr_data: '0, addr: 32'h10});
        run_access(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 0, o);
        e = sb_q.pop_front();
        checks++; if (!o.done) begin failures++; $display("FAIL lw_timeout got=no_ready exp=ready"); end
        checks++; if (o.rd !== e.rdata) begin failures++; $display("FAIL lw_rdata got=%h exp=%h", o.rd, e.rdata); end
        checks++; if (o.lat != e.lat) begin failures++; $display("FAIL lw_latency got=%0d exp=%0d", o.lat, e.lat); end
        checks++; if (o.seen_addr !== e.addr) begin failures++; $display("FAIL lw_pm_addr got=%h exp=%h", o.seen_addr, e.addr); end
        checks++; if (o.pulses != e.pulses) begin failures++; $display("FAIL lw_pulses got=%0d exp=%0d", o.pulses, e.pulses); end
    endtask

    task automatic test_sb();
        obs_t o; exp_t e;
        mem[4] = 32'h11223344;
        sb_q.push_back('{rdata: '0, err: 1'b0, lat: 4, pulses: 1, wr_data: 32'hA5223344, addr: 32'h10});
        run_access(1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h000000A5, 0, o);
        e = sb_q.pop_front();
        checks++; if (!o.done) begin failures++; $display("FAIL sb_timeout got=no_ready exp=ready"); end
        checks++; if (o.pulses != e.pulses) begin failures++; $display("FAIL sb_pulses got=%0d exp=%0d", o.pulses, e.pulses); end
        checks++; if (o.wr_data !== e.wr_data) begin failures++; $display("FAIL sb_pm_wdata got=%h exp=%h", o.wr_data, e.wr_data); end
        checks++; if (o.wr_addr !== e.addr) begin failures++; $display("FAIL sb_pm_addr got=%h exp=%h", o.wr_addr, e.addr); end
        checks++; if (o.lat != e.lat) begin failures++; $display("FAIL sb_latency got=%0d exp=%0d", o.lat, e.lat); end
        checks++; if (o.rd !== e.rdata) begin failures++; $display("FAIL sb_rdata got=%h exp=%h", o.rd, e.rdata); end
    endtask

    task automatic test_lh();
        obs_t o; exp_t e;
        mem[0] = 32'h80017F00;
        for (int s = 1; s >= 0; s--) begin
            sb_q.push_back('{rdata: (s == 1) ? 32'hFFFF8001 : 32'h00008001, err: 1'b0, lat: 2,
                             pulses: 0, wr_data: '0, addr: 32'h0});
            run_access(1'b0, SZ_HALF, 1'(s), 32'h2, 32'h0, 0, o);
            e = sb_q.pop_front();
            checks++; if (o.rd !== e.rdata) begin failures++; $display("FAIL lh_rdata sx=%0d got=%h exp=%h", s, o.rd, e.rdata); end
            checks++; if (o.lat != e.lat) begin failures++; $display("FAIL lh_latency sx=%0d got=%0d exp=%0d", s, o.lat, e.lat); end
        end
    endtask

    task automatic test_sw_busy();
        obs_t o; exp_t e;
        sb_q.push_back('{rdata: '0, err: 1'b0, lat: 0, pulses: 1, wr_data: 32'hCAFEF00D, addr: 32'h20});
        run_access(1'b1, SZ_WORD, 1'b0, 32'h20, 32'hCAFEF00D, 5, o);
        e = sb_q.pop_front();
        checks++; if (o.pulses != e.pulses) begin failures++; $display("FAIL sw_pulses got=%0d exp=%0d", o.pulses, e.pulses); end
        checks++; if (o.wr_data !== e.wr_data) begin failures++; $display("FAIL sw_pm_wdata got=%h exp=%h", o.wr_data, e.wr_data); end
        checks++; if (o.wr_addr !== e.addr) begin failures++; $display("FAIL sw_pm_addr got=%h exp=%h", o.wr_addr, e.addr); end
        checks++; if (o.drop_to_ready != 1) begin failures++; $display("FAIL sw_busy_to_ready got=%0d exp=1", o.drop_to_ready); end
        checks++; if (o.rd !== e.rdata) begin failures++; $display("FAIL sw_rdata got=%h exp=%h", o.rd, e.rdata); end
        sb_q.push_back('{rdata: 32'hCAFEF00D, err: 1'b0, lat: 2, pulses: 0, wr_data: '0, addr: 32'h20});
        run_access(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 0, o);
        e = sb_q.pop_front();
        checks++; if (o.rd !== e.rdata) begin failures++; $display("FAIL sw_readback got=%h exp=%h", o.rd, e.rdata); end
    endtask

    task automatic test_reset_mid();
        obs_t o; exp_t e;
        logic seen;
        int wr_seen;
        // Reset during WR_WAIT of a word store.
        @(negedge clk50M);
        req = 1'b1; is_write = 1'b1; size = SZ_WORD; addr = 32'h40; wdata = 32'h12345678;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk50M);
            if (pm_is_write) begin pm_busy = 1'b1; seen = 1'b1; end
            else if (seen) begin
                #2 rst_n = 1'b0; #1;
                checks++; if (pm_is_write !== 1'b0) begin failures++; $display("FAIL rstmid_pm_is_write got=%b exp=0", pm_is_write); end
                checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b exp=0", ready); end
                checks++; if (pm_addr !== 32'h0) begin failures++; $display("FAIL rstmid_pm_addr got=%h exp=0", pm_addr); end
                break;
            end
        end
        checks++; if (!seen) begin failures++; $display("FAIL rstmid_no_pulse got=0 exp=1"); end
        req = 1'b0; pm_busy = 1'b0;
        @(negedge clk50M); rst_n = 1'b1;
        $display("txn reset during WR_WAIT");
        // Reset while the write pulse itself is high.
        @(negedge clk50M);
        req = 1'b1; is_write = 1'b1; size = SZ_WORD; addr = 32'h44; wdata = 32'h0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk50M);
            if (pm_is_write) begin
                seen = 1'b1;
                #1 rst_n = 1'b0; #1;
                checks++; if (pm_is_write !== 1'b0) begin failures++; $display("FAIL rstpulse_pm_is_write got=%b exp=0", pm_is_write); end
                break;
            end
        end
        checks++; if (!seen) begin failures++; $display("FAIL rstpulse_no_pulse got=0 exp=1"); end
        req = 1'b0;
        @(negedge clk50M); rst_n = 1'b1;
        $display("txn reset during WR_PULSE");
        // Reset during the read phase of a sub-word store must not leave a write behind.
        @(negedge clk50M);
        req = 1'b1; is_write = 1'b1; size = SZ_BYTE; addr = 32'h11; wdata = 32'h5A;
        @(negedge clk50M);
        #1 rst_n = 1'b0; req = 1'b0;
        @(negedge clk50M); rst_n = 1'b1;
        wr_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk50M);
            if (pm_is_write) wr_seen++;
        end
        checks++; if (wr_seen != 0) begin failures++; $display("FAIL rstrmw_pulses got=%0d exp=0", wr_seen); end
        $display("txn reset during RMW read");
        mem[4] = 32'h600DF00D;
        sb_q.push_back('{rdata: 32'h600DF00D, err: 1'b0, lat: 2, pulses: 0, wr_data: '0, addr: 32'h10});
        run_access(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 0, o);
        e = sb_q.pop_front();
        checks++; if (o.rd !== e.rdata) begin failures++; $display("FAIL rstmid_lw_rdata got=%h exp=%h", o.rd, e.rdata); end
        checks++; if (o.lat != e.lat) begin failures++; $display("FAIL rstmid_lw_latency got=%0d exp=%0d", o.lat, e.lat); end
    endtask

    task automatic test_misalign();
        obs_t o; exp_t e;
        logic [31:0] prev;
        mem[0] = 32'h0BADF00D;
        prev = pm_addr;
`ifdef MEM_ALIGN_EXC_EN
        sb_q.push_back('{rdata: '0, err: 1'b1, lat: 1, pulses: 0, wr_data: '0, addr: prev});
`else
        sb_q.push_back('{rdata: 32'h0BADF00D, err: 1'b0, lat: 2, pulses: 0, wr_data: '0, addr: 32'h0});
`endif
        run_access(1'b0, SZ_WORD, 1'b0, 32'h2, 32'h0, 0, o);
        e = sb_q.pop_front();
        checks++; if (o.rd !== e.rdata) begin failures++; $display("FAIL mis_lw_rdata got=%h exp=%h", o.rd, e.rdata); end
        checks++; if (o.err !== e.err) begin failures++; $display("FAIL mis_lw_addr_err got=%b exp=%b", o.err, e.err); end
        checks++; if (o.lat != e.lat) begin failures++; $display("FAIL mis_lw_latency got=%0d exp=%0d", o.lat, e.lat); end
        checks++; if (o.seen_addr !== e.addr) begin failures++; $display("FAIL mis_lw_pm_addr got=%h exp=%h", o.seen_addr, e.addr); end
        mem[4] = 32'h11223344;
        prev = pm_addr;
`ifdef MEM_ALIGN_EXC_EN
        sb_q.push_back('{rdata: '0, err: 1'b1, lat: 1, pulses: 0, wr_data: '0, addr: prev});
`else
        sb_q.push_back('{rdata: '0, err: 1'b0, lat: 4, pulses: 1, wr_data: 32'h1122BEEF, addr: 32'h10});
`endif
        run_access(1'b1, SZ_HALF, 1'b0, 32'h11, 32'h0000BEEF, 0, o);
        e = sb_q.pop_front();
        checks++; if (o.pulses != e.pulses) begin failures++; $display("FAIL mis_sh_pulses got=%0d exp=%0d", o.pulses, e.pulses); end
        checks++; if (o.err !== e.err) begin failures++; $display("FAIL mis_sh_addr_err got=%b exp=%b", o.err, e.err); end
        checks++; if (e.pulses == 1 && o.wr_data !== e.wr_data) begin failures++; $display("FAIL mis_sh_pm_wdata got=%h exp=%h", o.wr_data, e.wr_data); end
    endtask

    task automatic test_back_to_back();
        obs_t o; exp_t e;
        logic [1:0]  sz;
        logic        w, sx;
        logic [31:0] a, wd, old;
        for (int i = 0; i < 16; i++) begin
            sz = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            sx = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 255));
            wd = $urandom;
`ifdef MEM_ALIGN_EXC_EN
            if (sz == SZ_HALF) a[0] = 1'b0;
            if (sz[1]) a[1:0] = 2'b00;
`endif
            old = mem[a[7:2]];
            if (w) sb_q.push_back('{rdata: '0, err: 1'b0, lat: sz[1] ? 3 : 4, pulses: 1,
                                    wr_data: ref_store(old, a, sz, wd), addr: {a[31:2], 2'b00}});
            else   sb_q.push_back('{rdata: ref_load(old, a, sz, sx), err: 1'b0, lat: 2, pulses: 0,
                                    wr_data: '0, addr: {a[31:2], 2'b00}});
            run_access(w, sz, sx, a, wd, 0, o);
            e = sb_q.pop_front();
            checks++; if (!o.done || o.rd !== e.rdata) begin failures++; $display("FAIL b2b_rdata i=%0d got=%h exp=%h", i, o.rd, e.rdata); end
            checks++; if (o.lat != e.lat || o.pulses != e.pulses) begin failures++; $display("FAIL b2b_timing i=%0d got=lat%0d/p%0d exp=lat%0d/p%0d", i, o.lat, o.pulses, e.lat, e.pulses); end
            checks++; if (e.pulses == 1 && (o.wr_data !== e.wr_data || o.wr_addr !== e.addr)) begin failures++; $display("FAIL b2b_write i=%0d got=%h@%h exp=%h@%h", i, o.wr_data, o.wr_addr, e.wr_data, e.addr); end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        test_reset();
        test_lw();
        test_sb();
        test_lh();
        test_sw_busy();
        test_reset_mid();
        test_misalign();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_adapter.md
Name: mem_access_adapter

Overview:
Sits directly upstream of the physical memory controller, between the CPU load/store unit and the word-only, aligned-only physical memory port.
- Converts byte, halfword and word loads/stores into aligned 32-bit accesses.
- Performs read-modify-write (RMW) for sub-word stores and sign/zero extension for sub-word loads.
- Generates the write pulse the downstream controller edge-detects, then waits out its busy/recovery period.

Parameters:
RD_WAIT_CYCLES, 1, cycles the aligned address is held before read data is sampled (1..15).
LITTLE_ENDIAN, 1, byte 0 lives at data[7:0] when 1; at data[31:24] when 0.

Ports:
clk50M  in  1  system clock; all logic on posedge.
rst_n  in  1  asynchronous, active-low reset.
req  in  1  access request; sampled only in IDLE; requester holds all request inputs stable until ready.
is_write  in  1  1 = store, 0 = load.
size  in  2  00 byte, 01 halfword, 10 word; 11 treated as word.
sign_ext  in  1  loads only: sign-extend sub-word result.
addr  in  32  byte address.
wdata  in  32  store data, right-justified.
rdata  out  32  load result; valid while ready=1.
ready  out  1  one-cycle completion pulse.
addr_err  out  1  misalignment flag, valid with ready (feature-dependent).
pm_addr  out  32  aligned word address to physical controller (bits[1:0]=00).
pm_is_write  out  1  write strobe to physical controller.
pm_wdata  out  32  write data to physical controller.
pm_rdata  in  32  combinational read data from physical controller.
pm_busy  in  1  physical controller busy.

Behaviour:
Reset:
- All outputs and internal latches 0; state IDLE.
- Reset asserted in any state returns to IDLE immediately; pm_is_write drops asynchronously.
- No partial RMW write is issued after reset.

States: IDLE, RD, WR_PULSE, WR_WAIT, DONE.

IDLE:
- On req=1, latch addr, size, sign_ext, wdata and is_write.
- pm_addr <= {addr[31:2], 2'b00}.
- Word store -> WR_PULSE. Any load or sub-word store -> RD; read counter cleared.

RD:
- Counter increments each cycle.
- When counter == RD_WAIT_CYCLES-1 and pm_busy=0, capture pm_rdata. While pm_busy=1, keep waiting with the counter saturated.
- Load -> DONE with the extracted result. Sub-word store -> merged word into pm_wdata, then WR_PULSE.

WR_PULSE:
- pm_is_write=1 for exactly one cycle, with pm_addr and pm_wdata stable.
- Always -> WR_WAIT.

WR_WAIT:
- pm_is_write=0.
- Minimum 1 cycle; leave when pm_busy=0 -> DONE.

DONE:
- ready=1 for one cycle; rdata holds the result.
- -> IDLE. A new req may be accepted on the next cycle (no back-to-back acceptance in DONE).

Extraction and merge (lane = addr[1:0] for bytes, addr[1] for halfwords):
- Byte load: selected lane, extended to 32 bits (sign or zero per sign_ext).
- Halfword load: selected half, extended likewise.
- Sub-word store: replaces only the target lane(s) of the read word with wdata[7:0] or wdata[15:0]; other bytes unchanged.
- Word load: pm_rdata passed through; sign_ext ignored.

Latency with RD_WAIT_CYCLES=1 and pm_busy=0 (N = posedge where req is sampled):
- Load: ready at N+2.
- Word store: ready at N+3.
- Sub-word store: ready at N+4.

General rules:
- pm_is_write is never high outside WR_PULSE.
- rdata is 0 after any store completes.

Optional Feature:
MEM_ALIGN_EXC_EN
- Defined: halfword with addr[0]=1, or word with addr[1:0]!=0, goes IDLE -> DONE with no physical access. addr_err=1 and rdata=0 with ready.
- Undefined: addr_err tied 0. Low address bits below the access size are ignored: halfword uses addr[1] only; word uses the aligned address.

Decomposition:
- Package mem_access_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state encoding, RD_WAIT counter width (4).
- One sub-module, byte_lane_unit (combinational), provides both functions:
  - extract: word, lane, size, sign_ext -> rdata.
  - merge: word, lane, size, wdata -> merged word.

Test Plan:
1. LW addr 0x00000010, pm_rdata 0xDEADBEEF -> rdata 0xDEADBEEF with ready at N+2; pm_addr 0x00000010; pm_is_write never asserted.
2. SB addr 0x00000013, wdata 0x000000A5, memory 0x11223344 (little-endian) -> read of 0x00000010, then one pm_is_write pulse with pm_wdata 0xA5223344; ready at N+4.
3. LH addr 0x00000002, pm_rdata 0x80017F00: sign_ext=1 -> rdata 0xFFFF8001; sign_ext=0 -> 0x00008001.
4. SW addr 0x00000020, pm_busy held 1 for 5 cycles after the pulse -> exactly one pm_is_write pulse; ready one cycle after pm_busy falls.
5. rst_n pulled low during WR_WAIT -> pm_is_write and ready 0 immediately; the next LW completes normally with correct data.
6. With MEM_ALIGN_EXC_EN, LW addr 0x00000002 -> ready and addr_err at N+1, rdata 0, no pm activity. Without the macro: same access reads the word at 0x00000000, addr_err 0.
